// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding, counter sizing and sign helper for the sequential divider
package seq_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int MAX_W = 64;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);
  function automatic logic [MAX_W-1:0] twos(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand and result valid/ready handshake bundle
interface seq_divider_if import seq_div_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             in_valid, in_ready, is_signed;
  logic             out_valid, out_ready, div_by_zero, overflow;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  modport master(output in_valid, dividend, divisor, is_signed, out_ready,
                 input in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
  modport slave(input in_valid, dividend, divisor, is_signed, out_ready,
                output in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/seq_div_step.sv
// seq_div_step: one restoring step, shift in a dividend bit and subtract the divisor if it fits
module seq_div_step #(parameter int WIDTH = 8) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);
  logic [WIDTH+1:0] w_sh, w_diff;
  assign w_sh   = {i_rem, i_bit};
  assign w_diff = w_sh - (WIDTH+2)'(i_dvs);
  assign o_qbit = ~w_diff[WIDTH+1];
  assign o_rem  = o_qbit ? w_diff[WIDTH:0] : w_sh[WIDTH:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock, signed/unsigned
module seq_divider import seq_div_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = cnt_bits(WIDTH);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem, w_rem;
  logic [WIDTH-1:0] r_quo, r_dvs, r_q, r_r, w_qmag, w_dmag, w_vmag;
  logic             r_neg_q, r_neg_r, r_ovf_p, r_dbz, r_ovf;
  logic             w_acc, w_sgn, w_dsgn, w_vsgn, w_zero, w_last, w_qbit;

  assign w_acc  = bus.in_valid && r_state == IDLE;
  assign w_sgn  = SIGNED_EN && bus.is_signed;
  assign w_dsgn = w_sgn && bus.dividend[WIDTH-1];
  assign w_vsgn = w_sgn && bus.divisor[WIDTH-1];
  assign w_zero = bus.divisor == '0;
  assign w_dmag = WIDTH'(twos(MAX_W'(bus.dividend), w_dsgn));
  assign w_vmag = WIDTH'(twos(MAX_W'(bus.divisor), w_vsgn));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_qmag = {r_quo[WIDTH-2:0], w_qbit};

  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_quo[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_rem),
    .o_qbit(w_qbit)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // next state and handshake outputs; divide by zero skips the iteration
  always_comb begin
    bus.in_ready  = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    w_next = r_state == IDLE ? (bus.in_valid ? (w_zero ? DONE : CALC) : IDLE) :
             r_state == CALC ? (w_last ? DONE : CALC) :
             (bus.out_ready ? IDLE : DONE);
  end

  // operand capture, iteration, and sign fix-up of the final step into the result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf_p <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_acc) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_dmag;
      r_dvs   <= w_vmag;
      r_neg_q <= w_dsgn ^ w_vsgn;
      r_neg_r <= w_dsgn;
      r_ovf_p <= w_sgn && bus.dividend == {1'b1, {(WIDTH-1){1'b0}}} && &bus.divisor;
      r_q     <= w_zero ? '1 : '0;
      r_r     <= w_zero ? bus.dividend : '0;
      r_dbz   <= w_zero;
      r_ovf   <= 1'b0;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem;
      r_quo <= w_qmag;
      if (w_last) begin
        r_q   <= WIDTH'(twos(MAX_W'(w_qmag), r_neg_q));
        r_r   <= WIDTH'(twos(MAX_W'(w_rem[WIDTH-1:0]), r_neg_r));
        r_ovf <= r_ovf_p;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_divider_if #(.WIDTH(8)) bus();
  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {div_by_zero, overflow, quotient, remainder}
  function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ia, ib, q, r;
    if (b == 8'd0) return {2'b10, 8'hFF, a};
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    if (s && ia == -128 && ib == -1) return {2'b01, 8'h80, 8'h00};
    q = ia / ib;
    r = ia % ib;
    return {2'b00, q[7:0], r[7:0]};
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.dividend  = 8'($urandom);
    bus.divisor   = 8'($urandom);
    bus.is_signed = 1'($urandom);
  endtask

  task automatic wait_result(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    int e;
    logic [17:0] m;
    e = 1;
    m = model(a, b, s);
    while (!bus.out_valid && e < 64) begin
      @(negedge clk);
      e++;
    end
    chk({tag, ".latency"}, 32'(e), (b == 8'd0) ? 32'd1 : 32'd9);
    chk({tag, ".quotient"}, 32'(bus.quotient), 32'(m[15:8]));
    chk({tag, ".remainder"}, 32'(bus.remainder), 32'(m[7:0]));
    chk({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(m[17]));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m[16]));
  endtask

  task automatic hold_check(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag, input int n);
    logic [17:0] m;
    m = model(a, b, s);
    repeat (n) begin
      @(negedge clk);
      chk({tag, ".hold"}, {12'd0, bus.out_valid, bus.in_ready, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder},
          {12'd0, 1'b1, 1'b0, m[17], m[16], m[15:8], m[7:0]});
    end
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic job(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag, input int hold);
    issue(a, b, s, tag);
    wait_result(a, b, s, tag);
    hold_check(a, b, s, tag, hold);
    release_out(tag);
  endtask

  initial begin
    logic [7:0] a, b;
    logic s;
    int quiet;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 8'd0;
    bus.is_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.quotient", 32'(bus.quotient), 32'd0);
    chk("reset.remainder", 32'(bus.remainder), 32'd0);
    chk("reset.flags", 32'({bus.div_by_zero, bus.overflow}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    job(8'd200, 8'd7, 1'b0, "u200_7", 0);
    job(8'hF9, 8'd2, 1'b1, "s-7_2", 0);
    job(8'd7, 8'hFE, 1'b1, "s7_-2", 0);
    job(8'd13, 8'd0, 1'b0, "dz13", 2);
    job(8'h80, 8'hFF, 1'b1, "s_ovf", 0);
    job(8'h80, 8'hFF, 1'b0, "u128_255", 0);

    issue(8'd100, 8'd9, 1'b0, "bp");
    wait_result(8'd100, 8'd9, 1'b0, "bp");
    hold_check(8'd100, 8'd9, 1'b0, "bp", 5);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor = 8'd6;
    bus.is_signed = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp.handshake_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp.not_accepted", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.accepted_next", 32'(bus.in_ready), 32'd0);
    wait_result(8'd50, 8'd6, 1'b0, "bp2");
    release_out("bp2");

    issue(8'd99, 8'd5, 1'b0, "rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.quotient", 32'(bus.quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) quiet = 0;
    end
    chk("rst.no_result", 32'(quiet), 32'd1);
    job(8'd15, 8'd4, 1'b0, "u15_4", 0);

    repeat (300) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      job(a, b, s, "rnd", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
